// File: rtl/run_step_ctrl.sv
// run_step_ctrl: debounced single-step clock-enable burst generator with registered register readout.
module run_step_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STEP_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic              fastclk,
  input  logic              reset_n,
  input  logic              switch_run,
  input  logic [4:0]        swith_select,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [4:0]        rf_read_addr,
  output logic [DATA_W-1:0] reg_read_data_1,
  output logic              cpu_clk_en,
  output logic [CNT_W-1:0]  step_count,
  output logic              busy
);
  localparam int MAXC = (DEBOUNCE_CYCLES > STEP_CYCLES) ? DEBOUNCE_CYCLES : STEP_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STEP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ARM, STEP, RELEASE} state_t;
  state_t state;
  logic sync1, run_s, go;
  logic [CW-1:0] cnt;
  // one counter serves both debounce windows and the burst length
  assign go = run_s && ((state == IDLE && DEBOUNCE_CYCLES == 1) || (state == ARM && cnt == D_LAST));
  assign busy = (state != IDLE);
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      run_s <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      cpu_clk_en <= 1'b0;
      step_count <= '0;
      rf_read_addr <= '0;
      reg_read_data_1 <= '0;
    end else begin
      sync1 <= switch_run;
      run_s <= sync1;
      rf_read_addr <= swith_select;
      reg_read_data_1 <= rf_read_data;
      if (go) begin
        state <= STEP;
        cnt <= '0;
        cpu_clk_en <= 1'b1;
        step_count <= step_count + CNT_W'(1);
      end else begin
        case (state)
          IDLE: if (run_s) begin
            state <= ARM;
            cnt <= CW'(1);
          end
          ARM: if (!run_s) begin
            state <= IDLE;
            cnt <= '0;
          end else cnt <= cnt + CW'(1);
          STEP: if (cnt == S_LAST) begin
            state <= RELEASE;
            cnt <= '0;
            cpu_clk_en <= 1'b0;
          end else cnt <= cnt + CW'(1);
          RELEASE: if (run_s) cnt <= '0;
          else if (cnt == D_LAST) begin
            state <= IDLE;
            cnt <= '0;
          end else cnt <= cnt + CW'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_run_step_ctrl.sv
// tb_run_step_ctrl: directed checks plus a per-cycle behavioural model for two configurations.
module tb_run_step_ctrl;
  logic clk = 1'b0;
  logic [1:0] rstn = 2'b00, sw = 2'b00, en, busy;
  logic [1:0][4:0] sel = '0;
  logic [4:0] addr_a, addr_b;
  logic [31:0] data_a, data_b, rfd_a, rfd_b;
  logic [15:0] sc_a;
  logic [3:0] sc_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign rfd_a = 32'h1000_0000 + {27'd0, addr_a};
  assign rfd_b = 32'h1000_0000 + {27'd0, addr_b};
  run_step_ctrl u_a (.fastclk(clk), .reset_n(rstn[0]), .switch_run(sw[0]), .swith_select(sel[0]),
    .rf_read_data(rfd_a), .rf_read_addr(addr_a), .reg_read_data_1(data_a), .cpu_clk_en(en[0]),
    .step_count(sc_a), .busy(busy[0]));
  run_step_ctrl #(.CNT_W(4), .STEP_CYCLES(4)) u_b (.fastclk(clk), .reset_n(rstn[1]), .switch_run(sw[1]),
    .swith_select(sel[1]), .rf_read_data(rfd_b), .rf_read_addr(addr_b), .reg_read_data_1(data_b),
    .cpu_clk_en(en[1]), .step_count(sc_b), .busy(busy[1]));
  // ph: 0 waiting, 1 counting highs, 2 bursting, 3 waiting for a clean release
  typedef struct {
    int ph; int streak; int left; int steps;
    bit s1; bit s2; bit en; bit [4:0] addr; bit [31:0] data;
  } mst_t;
  mst_t ma, mb;
  task automatic model_step(input int d, input int s, input int cw, input logic sw_i,
                            input logic [4:0] sel_i, input mst_t a, output mst_t b);
    b = a;
    b.s1 = sw_i;
    b.s2 = a.s1;
    b.addr = sel_i;
    b.data = 32'h1000_0000 + 32'(a.addr);
    if (a.ph == 2) begin
      b.left = a.left - 1;
      if (b.left == 0) begin b.en = 0; b.ph = 3; b.streak = 0; end
    end else if (a.ph == 3) begin
      b.streak = a.s2 ? 0 : a.streak + 1;
      if (b.streak == d) begin b.ph = 0; b.streak = 0; end
    end else if (!a.s2) begin
      b.ph = 0; b.streak = 0;
    end else begin
      b.streak = a.streak + 1;
      b.ph = 1;
      if (b.streak == d) begin
        b.ph = 2; b.left = s; b.en = 1; b.steps = (a.steps + 1) % (1 << cw);
      end
    end
  endtask
  initial begin
    ma = '{default: 0};
    forever begin
      @(posedge clk or negedge rstn[0]);
      if (!rstn[0]) ma = '{default: 0};
      else model_step(8, 1, 16, sw[0], sel[0], ma, ma);
    end
  end
  initial begin
    mb = '{default: 0};
    forever begin
      @(posedge clk or negedge rstn[1]);
      if (!rstn[1]) mb = '{default: 0};
      else model_step(8, 4, 4, sw[1], sel[1], mb, mb);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #3;
    chk("a.en", 32'(en[0]), 32'(ma.en));
    chk("a.busy", 32'(busy[0]), 32'(ma.ph != 0));
    chk("a.count", 32'(sc_a), 32'(ma.steps));
    chk("a.addr", 32'(addr_a), 32'(ma.addr));
    chk("a.data", data_a, ma.data);
    chk("b.en", 32'(en[1]), 32'(mb.en));
    chk("b.busy", 32'(busy[1]), 32'(mb.ph != 0));
    chk("b.count", 32'(sc_b), 32'(mb.steps));
    chk("b.addr", 32'(addr_b), 32'(mb.addr));
    chk("b.data", data_b, mb.data);
  end
  function automatic bit [127:0] segs(input int a, input int b = 0, input int c = 0, input int d = 0);
    bit [127:0] p = '0;
    int n[4] = '{a, b, c, d};
    int pos = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < n[i]; j++) begin
        p[pos] = (i % 2 == 0);
        pos++;
      end
    return p;
  endfunction
  task automatic run(input int w, input bit [127:0] pat, input int len,
                     output int fe, output int ne, output int bf);
    bit seen = 0;
    fe = -1; ne = 0; bf = -1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      sw[w] = pat[k-1];
      sel[w] = 5'(k * 7 + w);
      @(posedge clk);
      #3;
      if (en[w]) begin ne++; if (fe < 0) fe = k; end
      if (busy[w]) seen = 1;
      else if (seen && bf < 0) bf = k;
    end
  endtask
  int fe, ne, bf, hits;
  initial begin
    sel[0] = 5'd16;
    repeat (3) @(posedge clk);
    #3;
    chk("rst.en", 32'(en[0]), 0);
    chk("rst.busy", 32'(busy[0]), 0);
    chk("rst.count", 32'(sc_a), 0);
    chk("rst.addr", 32'(addr_a), 0);
    chk("rst.data", data_a, 0);
    @(negedge clk);
    rstn = 2'b11;
    @(posedge clk);
    #3;
    chk("rd.addr", 32'(addr_a), 32'd16);
    @(posedge clk);
    #3;
    chk("rd.data", data_a, 32'h1000_0010);
    run(0, segs(5), 25, fe, ne, bf);
    chk("glitch.en_cycles", 32'(ne), 0);
    chk("glitch.busy_fall", 32'(bf), 8);
    chk("glitch.count", 32'(sc_a), 0);
    run(0, segs(16), 40, fe, ne, bf);
    chk("press.first_en", 32'(fe), 10);
    chk("press.en_cycles", 32'(ne), 1);
    chk("press.busy_fall", 32'(bf), 26);
    chk("press.count", 32'(sc_a), 1);
    run(0, segs(16, 3, 1, 8), 45, fe, ne, bf);
    chk("bounce.first_en", 32'(fe), 10);
    chk("bounce.en_cycles", 32'(ne), 1);
    chk("bounce.busy_fall", 32'(bf), 30);
    chk("bounce.count", 32'(sc_a), 2);
    for (int p = 1; p <= 16; p++) begin
      run(1, segs(12), 32, fe, ne, bf);
      chk("wrap.en_cycles", 32'(ne), 4);
      if (p == 1) chk("wrap.first_en", 32'(fe), 10);
      if (p == 15) chk("wrap.count15", 32'(sc_b), 15);
      if (p == 16) chk("wrap.count0", 32'(sc_b), 0);
    end
    hits = 0;
    for (int k = 0; k < 30 && hits < 2; k++) begin
      @(negedge clk);
      sw[1] = 1'b1;
      @(posedge clk);
      #3;
      if (en[1]) hits++;
    end
    chk("abort.en_seen", 32'(hits), 2);
    #1 rstn[1] = 1'b0;
    #1;
    chk("abort.en", 32'(en[1]), 0);
    chk("abort.count", 32'(sc_b), 0);
    chk("abort.busy", 32'(busy[1]), 0);
    repeat (3) @(posedge clk);
    #2 rstn[1] = 1'b1;
    run(1, segs(20), 40, fe, ne, bf);
    chk("rehold.first_en", 32'(fe), 10);
    chk("rehold.en_cycles", 32'(ne), 4);
    chk("rehold.count", 32'(sc_b), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
